// File: rtl/fetch_redirect_ctrl.sv
// Fetch-stage PC owner. Issues instruction-memory requests over a req/rdy
// handshake, redirects on taken branches from EX and squashes the wrong-path
// IF/ID and ID/EX contents. A redirect that lands while a fetch is still
// outstanding parks its target in pend_pc until the stale response drains.
//
// Handshake: imem_req is valid-like and imem_rdy is ready-like. A request
// completes on a cycle where both are 1. While imem_req=1 and imem_rdy=0,
// imem_addr is held stable.
//
// Optional build macro FETCH_REDIRECT_STATS_EN adds the redirect_cnt and
// discard_cnt counters. When the macro is not defined, both ports read 0.
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          PC_STEP      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        take_branch,
  input  logic [31:0] PC_branch,
  input  logic        stall,
  input  logic        halt,
  input  logic        imem_rdy,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] PC,
  output logic [31:0] PC_4,
  output logic        fetch_valid,
  output logic        flush_IF_ID,
  output logic        flush_ID_EX,
  output logic [31:0] redirect_cnt,
  output logic [31:0] discard_cnt
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc_q, pc_n;
  logic [31:0] pend_pc, pend_pc_n;
  logic [31:0] target;

  // Redirect targets are always word aligned.
  assign target    = PC_branch & ~32'h3;
  assign PC        = pc_q;
  // The PC only moves once a fetch completes, so it doubles as the held address.
  assign imem_addr = pc_q;
  assign PC_4      = pc_q + 32'(PC_STEP);

  // State, PC and pending-target registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= BOOT;
      pc_q    <= RESET_VECTOR;
      pend_pc <= 32'h0;
    end else begin
      state   <= state_n;
      pc_q    <= pc_n;
      pend_pc <= pend_pc_n;
    end
  end

  // Next-state, next-PC and handshake/flush outputs.
  always_comb begin
    state_n     = state;
    pc_n        = pc_q;
    pend_pc_n   = pend_pc;
    imem_req    = 1'b0;
    fetch_valid = 1'b0;
    flush_IF_ID = 1'b0;
    flush_ID_EX = 1'b0;
    case (state)
      BOOT: begin
        state_n = RUN;
      end
      RUN: begin
        imem_req    = 1'b1;
        fetch_valid = imem_rdy & ~take_branch;
        if (take_branch) begin
          // A halt or stall in this cycle is on the wrong path; ignore it.
          flush_IF_ID = 1'b1;
          flush_ID_EX = 1'b1;
          if (imem_rdy) begin
            pc_n = target;
          end else begin
            pend_pc_n = target;
            state_n   = DRAIN;
          end
        end else if (halt) begin
          state_n = HALTED;
        end else if (stall) begin
          fetch_valid = 1'b0;
        end else if (imem_rdy) begin
          pc_n = pc_q + 32'(PC_STEP);
        end
      end
      DRAIN: begin
        imem_req = 1'b1;
        if (take_branch) begin
          flush_IF_ID = 1'b1;
          flush_ID_EX = 1'b1;
          pend_pc_n   = target;
        end
        if (imem_rdy) begin
          // The stale response is dropped. The newest target wins.
          pc_n    = take_branch ? target : pend_pc;
          state_n = RUN;
        end
      end
      default: begin
        // HALTED: frozen until reset.
      end
    endcase
  end

`ifdef FETCH_REDIRECT_STATS_EN
  logic redirect_acc;
  logic discard_rsp;
  logic [31:0] redirect_q;
  logic [31:0] discard_q;

  assign redirect_acc = take_branch & ((state == RUN) | (state == DRAIN));
  assign discard_rsp  = imem_rdy & (((state == RUN) & take_branch) | (state == DRAIN));
  assign redirect_cnt = redirect_q;
  assign discard_cnt  = discard_q;

  // Wrapping event counters for accepted redirects and dropped responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_q <= 32'h0;
      discard_q  <= 32'h0;
    end else begin
      if (redirect_acc) redirect_q <= redirect_q + 32'd1;
      if (discard_rsp)  discard_q  <= discard_q + 32'd1;
    end
  end
`else
  assign redirect_cnt = 32'h0;
  assign discard_cnt  = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed testbench for fetch_redirect_ctrl. Inputs change 1 ns after the
// rising edge, and outputs are sampled 4 ns after the edge.
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        take_branch;
  logic [31:0] PC_branch;
  logic        stall;
  logic        halt;
  logic        imem_rdy;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] PC;
  logic [31:0] PC_4;
  logic        fetch_valid;
  logic        flush_IF_ID;
  logic        flush_ID_EX;
  logic [31:0] redirect_cnt;
  logic [31:0] discard_cnt;

  int vectors     = 0;
  int miscompares = 0;

  fetch_redirect_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .take_branch (take_branch),
    .PC_branch   (PC_branch),
    .stall       (stall),
    .halt        (halt),
    .imem_rdy    (imem_rdy),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .PC          (PC),
    .PC_4        (PC_4),
    .fetch_valid (fetch_valid),
    .flush_IF_ID (flush_IF_ID),
    .flush_ID_EX (flush_ID_EX),
    .redirect_cnt(redirect_cnt),
    .discard_cnt (discard_cnt)
  );

  // Clock generation: 10 ns period.
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Pulses reset between edges and returns inside the BOOT cycle.
  task automatic do_reset();
    cyc();
    rst = 1'b1; take_branch = 1'b0; PC_branch = 32'h0;
    stall = 1'b0; halt = 1'b0; imem_rdy = 1'b1;
    #2;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    cyc();
    rst = 1'b1; take_branch = 1'b0; PC_branch = 32'h0;
    stall = 1'b0; halt = 1'b0; imem_rdy = 1'b1;
    #2;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b exp 0", imem_req); end
    vectors++; if (PC !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h exp 00000000", PC); end
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr got %h exp 00000000", imem_addr); end
    vectors++; if ({fetch_valid, flush_IF_ID, flush_ID_EX} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b exp 000", {fetch_valid, flush_IF_ID, flush_ID_EX}); end
    vectors++; if ({redirect_cnt, discard_cnt} !== 64'h0) begin miscompares++; $display("FAIL reset_cnt got %h/%h exp 0/0", redirect_cnt, discard_cnt); end
    rst = 1'b0;
    #1;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL boot_req got %b exp 0", imem_req); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      #3;
      vectors++; if (PC !== 32'(4 * i)) begin miscompares++; $display("FAIL seq_pc%0d got %h exp %h", i, PC, 32'(4 * i)); end
      vectors++; if ({imem_req, fetch_valid} !== 2'b11) begin miscompares++; $display("FAIL seq_valid%0d got %b exp 11", i, {imem_req, fetch_valid}); end
    end
  endtask

  task automatic test_branch_ready();
    do_reset();
    repeat (5) cyc();
    take_branch = 1'b1; PC_branch = 32'h0000_0103;
    #3;
    vectors++; if (PC !== 32'h10) begin miscompares++; $display("FAIL br_pc_before got %h exp 00000010", PC); end
    vectors++; if (PC_4 !== 32'h14) begin miscompares++; $display("FAIL br_pc4 got %h exp 00000014", PC_4); end
    vectors++; if ({flush_IF_ID, flush_ID_EX, fetch_valid} !== 3'b110) begin miscompares++; $display("FAIL br_flush got %b exp 110", {flush_IF_ID, flush_ID_EX, fetch_valid}); end
    cyc();
    take_branch = 1'b0;
    #3;
    vectors++; if (PC !== 32'h100) begin miscompares++; $display("FAIL br_target got %h exp 00000100", PC); end
    vectors++; if ({imem_req, fetch_valid, flush_IF_ID} !== 3'b110) begin miscompares++; $display("FAIL br_after got %b exp 110", {imem_req, fetch_valid, flush_IF_ID}); end
  endtask

  task automatic test_drain();
    logic [31:0] exp_rc;
    logic [31:0] exp_dc;
`ifdef FETCH_REDIRECT_STATS_EN
    exp_rc = 32'd2; exp_dc = 32'd1;
`else
    exp_rc = 32'd0; exp_dc = 32'd0;
`endif
    do_reset();
    repeat (9) cyc();
    imem_rdy = 1'b0; take_branch = 1'b1; PC_branch = 32'h200;
    #3;
    vectors++; if ({imem_addr, flush_IF_ID, fetch_valid} !== {32'h20, 2'b10}) begin miscompares++; $display("FAIL dr_first got %h/%b/%b exp 00000020/1/0", imem_addr, flush_IF_ID, fetch_valid); end
    cyc();
    PC_branch = 32'h300;
    #3;
    vectors++; if ({imem_req, imem_addr, flush_ID_EX} !== {1'b1, 32'h20, 1'b1}) begin miscompares++; $display("FAIL dr_second got %b/%h/%b exp 1/00000020/1", imem_req, imem_addr, flush_ID_EX); end
    cyc();
    take_branch = 1'b0;
    #3;
    vectors++; if ({imem_addr, flush_IF_ID} !== {32'h20, 1'b0}) begin miscompares++; $display("FAIL dr_hold got %h/%b exp 00000020/0", imem_addr, flush_IF_ID); end
    cyc();
    imem_rdy = 1'b1;
    #3;
    vectors++; if ({imem_addr, fetch_valid} !== {32'h20, 1'b0}) begin miscompares++; $display("FAIL dr_discard got %h/%b exp 00000020/0", imem_addr, fetch_valid); end
    cyc();
    #3;
    vectors++; if (PC !== 32'h300) begin miscompares++; $display("FAIL dr_target got %h exp 00000300", PC); end
    vectors++; if (fetch_valid !== 1'b1) begin miscompares++; $display("FAIL dr_resume got %b exp 1", fetch_valid); end
    vectors++; if (redirect_cnt !== exp_rc) begin miscompares++; $display("FAIL dr_redirect_cnt got %0d exp %0d", redirect_cnt, exp_rc); end
    vectors++; if (discard_cnt !== exp_dc) begin miscompares++; $display("FAIL dr_discard_cnt got %0d exp %0d", discard_cnt, exp_dc); end
  endtask

  task automatic test_halt();
    do_reset();
    repeat (2) cyc();
    halt = 1'b1; take_branch = 1'b1; PC_branch = 32'h500;
    cyc();
    take_branch = 1'b0; halt = 1'b0;
    #3;
    vectors++; if ({imem_req, PC} !== {1'b1, 32'h500}) begin miscompares++; $display("FAIL halt_br got %b/%h exp 1/00000500", imem_req, PC); end
    halt = 1'b1;
    cyc();
    halt = 1'b0; take_branch = 1'b1; PC_branch = 32'h700;
    for (int i = 0; i < 3; i++) begin
      #3;
      vectors++; if ({imem_req, fetch_valid, flush_IF_ID, PC} !== {3'b000, 32'h500}) begin miscompares++; $display("FAIL halted%0d got %b%b%b/%h exp 000/00000500", i, imem_req, fetch_valid, flush_IF_ID, PC); end
      cyc();
    end
    take_branch = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    repeat (17) cyc();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3;
      vectors++; if ({PC, fetch_valid, imem_req} !== {32'h40, 2'b01}) begin miscompares++; $display("FAIL stall%0d got %h/%b/%b exp 00000040/0/1", i, PC, fetch_valid, imem_req); end
      cyc();
    end
    stall = 1'b0;
    #3;
    vectors++; if ({PC, fetch_valid} !== {32'h40, 1'b1}) begin miscompares++; $display("FAIL stall_rel got %h/%b exp 00000040/1", PC, fetch_valid); end
    cyc();
    imem_rdy = 1'b0;
    #3;
    vectors++; if (PC !== 32'h44) begin miscompares++; $display("FAIL stall_next got %h exp 00000044", PC); end
    cyc();
    #3;
    vectors++; if ({PC, fetch_valid} !== {32'h44, 1'b0}) begin miscompares++; $display("FAIL nordy_hold got %h/%b exp 00000044/0", PC, fetch_valid); end
    imem_rdy = 1'b1;
  endtask

  task automatic test_wrap();
    do_reset();
    cyc();
    take_branch = 1'b1; PC_branch = 32'hFFFF_FFFF;
    cyc();
    take_branch = 1'b0;
    #3;
    vectors++; if (PC !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_top got %h exp fffffffc", PC); end
    cyc();
    #3;
    vectors++; if (PC !== 32'h0) begin miscompares++; $display("FAIL wrap_zero got %h exp 00000000", PC); end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (3) cyc();
    imem_rdy = 1'b0; take_branch = 1'b1; PC_branch = 32'h900;
    cyc();
    #2;
    rst = 1'b1;
    #1;
    vectors++; if ({imem_req, fetch_valid, flush_IF_ID, flush_ID_EX} !== 4'b0000) begin miscompares++; $display("FAIL areset_flags got %b exp 0000", {imem_req, fetch_valid, flush_IF_ID, flush_ID_EX}); end
    vectors++; if ({PC, imem_addr} !== 64'h0) begin miscompares++; $display("FAIL areset_pc got %h/%h exp 0/0", PC, imem_addr); end
    vectors++; if ({redirect_cnt, discard_cnt} !== 64'h0) begin miscompares++; $display("FAIL areset_cnt got %h/%h exp 0/0", redirect_cnt, discard_cnt); end
    take_branch = 1'b0; imem_rdy = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  // Test sequence.
  initial begin
    rst = 1'b1; take_branch = 1'b0; PC_branch = 32'h0;
    stall = 1'b0; halt = 1'b0; imem_rdy = 1'b1;
    test_reset();
    test_branch_ready();
    test_drain();
    test_halt();
    test_stall();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
